// File: rtl/pipeline_debug_ctrl.sv
// Debug-unit sequencer for the MIPS pipeline: loads program words from the host link,
// runs or single-steps the pipeline, and dumps the register file back as bytes.
module pipeline_debug_ctrl #(
    parameter int                NB_REG     = 32,
    parameter int                NB_BYTE    = 8,
    parameter int                MEM_DEPTH  = 256,
    parameter int                N_REGS     = 32,
    parameter int                NB_CNT     = 32,
    parameter int                MAX_CYCLES = 1024,
    parameter logic [NB_REG-1:0] END_WORD   = NB_REG'(32'hFFFF_FFFF)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    input  logic               i_halt,
    input  logic [NB_REG-1:0]  i_dunit_reg,
    output logic               o_dunit_clk_en,
    output logic               o_dunit_reset_pc,
    output logic               o_dunit_w_mem,
    output logic [NB_REG-1:0]  o_dunit_addr,
    output logic [NB_REG-1:0]  o_dunit_data_if,
    output logic [NB_CNT-1:0]  o_cycle_count,
    output logic               o_busy
);
    localparam int NB_PER  = NB_REG / NB_BYTE;
    localparam int NB_BIDX = (NB_PER > 1) ? $clog2(NB_PER) : 1;
    localparam int NB_RUN  = $clog2(MAX_CYCLES + 1);

    localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(NB_PER - 1);
    localparam logic [NB_RUN-1:0]  LAST_RUN  = NB_RUN'(MAX_CYCLES - 1);
    localparam logic [NB_REG-1:0]  LAST_K    = NB_REG'(MEM_DEPTH - 1);
    localparam logic [NB_REG-1:0]  LAST_REG  = NB_REG'(N_REGS - 1);

    localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'(8'h43);
    localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CMD_DUMP = NB_BYTE'(8'h44);
    localparam logic [NB_BYTE-1:0] CMD_RST  = NB_BYTE'(8'h52);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, STEP, DUMP} state_t;

    state_t               state;
    logic [NB_BIDX-1:0]   byte_idx;
    logic [NB_REG-1:0]    word_sr;
    logic [NB_REG-1:0]    load_k;
    logic [NB_RUN-1:0]    run_cnt;
    logic                 halt_latch;
    logic                 settle;
    logic [NB_REG-1:0]    assembled;
    logic [NB_REG-1:0]    k_wr;
    logic [NB_CNT-1:0]    count_inc;

    assign assembled = (word_sr << NB_BYTE) | NB_REG'(i_rx_data);
    // A write pulse still in flight has not yet advanced load_k.
    assign k_wr      = o_dunit_w_mem ? load_k + NB_REG'(1) : load_k;
    assign count_inc = (o_cycle_count == '1) ? o_cycle_count : o_cycle_count + NB_CNT'(1);
    assign o_busy    = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state            <= IDLE;
            byte_idx         <= '0;
            word_sr          <= '0;
            load_k           <= '0;
            run_cnt          <= '0;
            halt_latch       <= 1'b0;
            settle           <= 1'b0;
            o_tx_data        <= '0;
            o_tx_valid       <= 1'b0;
            o_dunit_clk_en   <= 1'b0;
            o_dunit_reset_pc <= 1'b1;
            o_dunit_w_mem    <= 1'b0;
            o_dunit_addr     <= '0;
            o_dunit_data_if  <= '0;
            o_cycle_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                state            <= LOAD;
                                load_k           <= '0;
                                byte_idx         <= '0;
                                o_dunit_reset_pc <= 1'b1;
                            end
                            CMD_RUN: if (!halt_latch) begin
                                state            <= RUN;
                                run_cnt          <= '0;
                                o_dunit_clk_en   <= 1'b1;
                                o_dunit_reset_pc <= 1'b0;
                            end
                            CMD_STEP: if (!halt_latch) begin
                                state            <= STEP;
                                o_dunit_clk_en   <= 1'b1;
                                o_dunit_reset_pc <= 1'b0;
                            end
                            CMD_DUMP: begin
                                state        <= DUMP;
                                o_dunit_addr <= '0;
                                settle       <= 1'b1;
                                byte_idx     <= '0;
                            end
                            CMD_RST: begin
                                o_dunit_reset_pc <= 1'b1;
                                o_cycle_count    <= '0;
                                halt_latch       <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                LOAD: begin
                    o_dunit_w_mem <= 1'b0;
                    if (o_dunit_w_mem) load_k <= load_k + NB_REG'(1);
                    if (o_dunit_w_mem && load_k == LAST_K) begin
                        state <= IDLE;
                    end else if (i_rx_valid) begin
                        word_sr <= assembled;
                        if (byte_idx == LAST_BYTE) begin
                            byte_idx <= '0;
                            if (assembled == END_WORD) begin
                                state <= IDLE;
                            end else begin
                                o_dunit_w_mem   <= 1'b1;
                                o_dunit_addr    <= k_wr << 2;
                                o_dunit_data_if <= assembled;
                            end
                        end else begin
                            byte_idx <= byte_idx + NB_BIDX'(1);
                        end
                    end
                end
                RUN: begin
                    o_cycle_count <= count_inc;
                    // Halt wins over the watchdog so the latch records it.
                    if (i_halt) begin
                        halt_latch     <= 1'b1;
                        o_dunit_clk_en <= 1'b0;
                        state          <= IDLE;
                    end else if (run_cnt == LAST_RUN) begin
                        o_dunit_clk_en <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        run_cnt <= run_cnt + NB_RUN'(1);
                    end
                end
                STEP: begin
                    o_cycle_count  <= count_inc;
                    o_dunit_clk_en <= 1'b0;
                    state          <= IDLE;
                    if (i_halt) halt_latch <= 1'b1;
                end
                DUMP: begin
                    if (settle) begin
                        settle     <= 1'b0;
                        o_tx_valid <= 1'b1;
                        o_tx_data  <= i_dunit_reg[NB_REG-1 -: NB_BYTE];
                        word_sr    <= i_dunit_reg << NB_BYTE;
                        byte_idx   <= '0;
                    end else if (o_tx_valid && i_tx_ready) begin
                        if (byte_idx == LAST_BYTE) begin
                            o_tx_valid <= 1'b0;
                            if (o_dunit_addr == LAST_REG) begin
                                state <= IDLE;
                            end else begin
                                o_dunit_addr <= o_dunit_addr + NB_REG'(1);
                                settle       <= 1'b1;
                            end
                        end else begin
                            byte_idx  <= byte_idx + NB_BIDX'(1);
                            o_tx_data <= word_sr[NB_REG-1 -: NB_BYTE];
                            word_sr   <= word_sr << NB_BYTE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Bench for pipeline_debug_ctrl: command table, directed multi-cycle sequences and
// randomized load/run/dump traffic against a behavioural model.
module tb_pipeline_debug_ctrl;
    localparam int MEM_DEPTH  = 8;
    localparam int N_REGS     = 4;
    localparam int MAX_CYCLES = 16;
    localparam logic [31:0] END_W = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, rx_valid, tx_valid, tx_ready, halt;
    logic [7:0]  rx_data, tx_data;
    logic [31:0] dunit_reg, dunit_addr, data_if, cycle_count;
    logic        clk_en, reset_pc, w_mem, busy;
    logic [31:0] regs [N_REGS];

    assign dunit_reg = regs[dunit_addr[1:0]];

    pipeline_debug_ctrl #(
        .NB_REG(32), .NB_BYTE(8), .MEM_DEPTH(MEM_DEPTH), .N_REGS(N_REGS),
        .NB_CNT(32), .MAX_CYCLES(MAX_CYCLES), .END_WORD(END_W)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
        .i_halt(halt), .i_dunit_reg(dunit_reg), .o_dunit_clk_en(clk_en),
        .o_dunit_reset_pc(reset_pc), .o_dunit_w_mem(w_mem), .o_dunit_addr(dunit_addr),
        .o_dunit_data_if(data_if), .o_cycle_count(cycle_count), .o_busy(busy)
    );

    // Second instance with a narrow counter to reach saturation quickly.
    logic        rx2_valid, tx2_valid, en2, rpc2, wmem2, busy2;
    logic [7:0]  rx2_data, tx2_data;
    logic [31:0] addr2, data2;
    logic [3:0]  count2;

    pipeline_debug_ctrl #(
        .NB_REG(32), .NB_BYTE(8), .MEM_DEPTH(4), .N_REGS(2),
        .NB_CNT(4), .MAX_CYCLES(32), .END_WORD(END_W)
    ) dut_sat (
        .i_clk(clk), .i_reset(reset), .i_rx_data(rx2_data), .i_rx_valid(rx2_valid),
        .o_tx_data(tx2_data), .o_tx_valid(tx2_valid), .i_tx_ready(1'b1),
        .i_halt(1'b0), .i_dunit_reg(32'h0), .o_dunit_clk_en(en2),
        .o_dunit_reset_pc(rpc2), .o_dunit_w_mem(wmem2), .o_dunit_addr(addr2),
        .o_dunit_data_if(data2), .o_cycle_count(count2), .o_busy(busy2)
    );

    int checks = 0;
    int failures = 0;
    logic [63:0] wr_q [$];
    logic [7:0]  exp_q [$];
    int model_count;
    bit model_latch;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: memory writes and accepted transmit bytes.
    logic       tx_pend = 1'b0;
    logic [7:0] tx_prev = 8'h0;
    always @(negedge clk) begin
        if (w_mem) begin
            if (wr_q.size() == 0) check("wr_unexpected", {63'h0, w_mem}, 64'h0);
            else check("wr_addr_data", {dunit_addr, data_if}, wr_q.pop_front());
        end
        if (tx_valid) begin
            if (tx_pend) check("tx_stable", {56'h0, tx_data}, {56'h0, tx_prev});
            if (tx_ready) begin
                if (exp_q.size() == 0) check("tx_unexpected", {63'h0, tx_valid}, 64'h0);
                else check("tx_byte", {56'h0, tx_data}, {56'h0, exp_q.pop_front()});
                tx_pend <= 1'b0;
            end else begin
                tx_pend <= 1'b1;
                tx_prev <= tx_data;
            end
        end else begin
            tx_pend <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_valid = 1'b0;
        rx2_valid = 1'b0;
        halt = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        wr_q.delete();
        exp_q.delete();
        model_count = 0;
        model_latch = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        logic [31:0] v;
        v = w;
        for (int i = 3; i >= 0; i--) begin
            send(v[i*8 +: 8]);
            if (gaps) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic load_random(input int n);
        logic [31:0] w;
        send(8'h4C);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            if (w == END_W) w = 32'h0;
            wr_q.push_back({32'(4 * i), w});
            send_word(w, 1'b1);
        end
        if (n < MEM_DEPTH) send_word(END_W, 1'b1);
        tick();
        tick();
        check("rload_idle", {63'h0, busy}, 64'h0);
        check("rload_q_empty", 64'(wr_q.size()), 64'h0);
        check("rload_reset_pc", {63'h0, reset_pc}, 64'h1);
    endtask

    // h = enabled cycle at which halt is raised; 0 = never.
    task automatic run_to(input int h);
        int n, exp_n;
        bit halts;
        halts = (h > 0) && (h <= MAX_CYCLES);
        exp_n = halts ? h : MAX_CYCLES;
        send(8'h43);
        n = 0;
        for (int c = 0; c < 200; c++) begin
            if (!clk_en) break;
            n++;
            halt = (n == h);
            tick();
            halt = 1'b0;
        end
        model_count += exp_n;
        if (halts) model_latch = 1'b1;
        check("run_cycles", 64'(n), 64'(exp_n));
        check("run_idle", {63'h0, busy}, 64'h0);
        check("run_count", {32'h0, cycle_count}, 64'(model_count));
        check("run_reset_pc", {63'h0, reset_pc}, 64'h0);
    endtask

    task automatic step_once();
        send(8'h53);
        check("step_en", {63'h0, clk_en}, {63'h0, !model_latch});
        tick();
        if (!model_latch) model_count++;
        check("step_en_off", {63'h0, clk_en}, 64'h0);
        check("step_idle", {63'h0, busy}, 64'h0);
    endtask

    // mode 0: ready held high, 1: ready toggling, 2: random ready.
    task automatic dump(input int mode);
        int c;
        bit en_seen;
        for (int r = 0; r < N_REGS; r++)
            for (int b = 3; b >= 0; b--) exp_q.push_back(regs[r][b*8 +: 8]);
        send(8'h44);
        c = 0;
        en_seen = 1'b0;
        while (busy && c < 1000) begin
            tx_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            if (clk_en) en_seen = 1'b1;
            tick();
            c++;
        end
        tx_ready = 1'b0;
        check("dump_done", {63'h0, busy}, 64'h0);
        check("dump_q_empty", 64'(exp_q.size()), 64'h0);
        check("dump_clk_en", {63'h0, en_seen}, 64'h0);
        if (mode == 0) check("dump_cycles", 64'(c), 64'(N_REGS * 5));
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic       busy;
        logic       clk_en;
        logic       reset_pc;
    } vec_t;
    vec_t vecs [8];

    logic [31:0] load_words [3];

    initial begin
        vecs[0] = '{8'h4C, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{8'h43, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h53, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h44, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h52, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h6C, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{8'hFF, 1'b0, 1'b0, 1'b1};
        load_words[0] = 32'h2001_0005;
        load_words[1] = 32'h2002_0005;
        load_words[2] = 32'h1022_0004;
        for (int r = 0; r < N_REGS; r++) regs[r] = 32'h0;
        rx_data = 8'h0; rx_valid = 1'b0; tx_ready = 1'b0; halt = 1'b0;
        rx2_data = 8'h0; rx2_valid = 1'b0; reset = 1'b1;

        do_reset();
        check("rst_reset_pc", {63'h0, reset_pc}, 64'h1);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_clk_en", {63'h0, clk_en}, 64'h0);
        check("rst_w_mem", {63'h0, w_mem}, 64'h0);
        check("rst_tx_valid", {63'h0, tx_valid}, 64'h0);
        check("rst_tx_data", {56'h0, tx_data}, 64'h0);
        check("rst_addr", {32'h0, dunit_addr}, 64'h0);
        check("rst_data_if", {32'h0, data_if}, 64'h0);
        check("rst_count", {32'h0, cycle_count}, 64'h0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            send(vecs[i].cmd);
            check("cmd_busy", {63'h0, busy}, {63'h0, vecs[i].busy});
            check("cmd_clk_en", {63'h0, clk_en}, {63'h0, vecs[i].clk_en});
            check("cmd_reset_pc", {63'h0, reset_pc}, {63'h0, vecs[i].reset_pc});
        end

        // Program load, back-to-back bytes.
        do_reset();
        send(8'h4C);
        for (int i = 0; i < 3; i++) begin
            wr_q.push_back({32'(4 * i), load_words[i]});
            send_word(load_words[i], 1'b0);
            check("load_w_mem", {63'h0, w_mem}, 64'h1);
            check("load_addr", {32'h0, dunit_addr}, 64'(4 * i));
            check("load_data", {32'h0, data_if}, {32'h0, load_words[i]});
        end
        send_word(END_W, 1'b0);
        check("load_end_idle", {63'h0, busy}, 64'h0);
        check("load_end_reset_pc", {63'h0, reset_pc}, 64'h1);
        check("load_q_empty", 64'(wr_q.size()), 64'h0);

        // Run to halt, then commands blocked by the halt latch.
        run_to(10);
        check("halt_en_off", {63'h0, clk_en}, 64'h0);
        send(8'h43);
        check("halted_c_ignored", {63'h0, busy}, 64'h0);
        step_once();
        check("halted_count", {32'h0, cycle_count}, 64'(model_count));

        // Step after 'R'.
        send(8'h52);
        model_count = 0;
        model_latch = 1'b0;
        check("r_count_clear", {32'h0, cycle_count}, 64'h0);
        check("r_reset_pc", {63'h0, reset_pc}, 64'h1);
        repeat (3) step_once();
        check("step_count", {32'h0, cycle_count}, 64'h3);

        // Watchdog, then halt coinciding with the limit.
        run_to(0);
        step_once();
        send(8'h52);
        model_count = 0;
        run_to(MAX_CYCLES);
        step_once();
        check("halt_at_limit_count", {32'h0, cycle_count}, 64'(MAX_CYCLES));

        // Register dump with backpressure and with ready held high.
        regs[0] = 32'd0; regs[1] = 32'd5; regs[2] = 32'd5; regs[3] = 32'd2;
        dump(1);
        dump(0);

        // Reset partway through a load word.
        send(8'h4C);
        send(8'hDE);
        send(8'hAD);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_w_mem", {63'h0, w_mem}, 64'h0);
        check("abort_busy", {63'h0, busy}, 64'h0);
        check("abort_reset_pc", {63'h0, reset_pc}, 64'h1);
        check("abort_count", {32'h0, cycle_count}, 64'h0);
        repeat (3) tick();
        send(8'h4C);
        wr_q.push_back({32'h0, 32'hCAFE_0001});
        send_word(32'hCAFE_0001, 1'b0);
        check("reload_addr", {32'h0, dunit_addr}, 64'h0);
        send_word(END_W, 1'b0);
        check("reload_q_empty", 64'(wr_q.size()), 64'h0);

        // Reset while a transmit byte is waiting on the handshake.
        tx_ready = 1'b0;
        send(8'h44);
        repeat (3) tick();
        check("dump_hold_valid", {63'h0, tx_valid}, 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("dump_abort_valid", {63'h0, tx_valid}, 64'h0);
        check("dump_abort_busy", {63'h0, busy}, 64'h0);

        // Randomized traffic against the model.
        do_reset();
        load_random(MEM_DEPTH);
        for (int it = 0; it < 6; it++) begin
            load_random($urandom_range(1, MEM_DEPTH));
            send(8'h52);
            model_count = 0;
            model_latch = 1'b0;
            run_to($urandom_range(1, 20));
            step_once();
            check("rand_count", {32'h0, cycle_count}, 64'(model_count));
            for (int r = 0; r < N_REGS; r++) regs[r] = $urandom;
            dump(2);
        end

        // Counter saturation on the narrow instance.
        begin
            int n2;
            rx2_data = 8'h43;
            rx2_valid = 1'b1;
            tick();
            rx2_valid = 1'b0;
            n2 = 0;
            for (int c = 0; c < 100; c++) begin
                if (!en2) break;
                n2++;
                tick();
            end
            check("sat_cycles", 64'(n2), 64'd32);
            check("sat_count", {60'h0, count2}, 64'hF);
            check("sat_idle", {63'h0, busy2}, 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_debug_ctrl.md
# pipeline_debug_ctrl

Synthesizable debug controller for the MIPS pipeline's debug-unit port. It takes a command/data byte stream from the host link and loads program words into instruction memory. It then runs the pipeline continuously or one step at a time, and dumps register-file contents back as bytes. It sits between the UART receive/transmit blocks and the pipeline's `i_dunit_*` / `o_dunit_*` ports, and replaces manual bench-driven loading with a parametrised, mode-capable sequencer.

## Interface
Parameters:
- `NB_REG`, 32: data word width; must be a multiple of `NB_BYTE`.
- `NB_BYTE`, 8: link byte width.
- `MEM_DEPTH`, 256: maximum number of program words accepted per load.
- `N_REGS`, 32: number of registers dumped.
- `NB_CNT`, 32: cycle counter width.
- `MAX_CYCLES`, 1024: continuous-run watchdog limit in cycles.
- `END_WORD`, 32'hFFFF_FFFF: load terminator word.

Ports:
- `i_clk`, in, 1: clock.
- `i_reset`, in, 1: synchronous active-high reset.
- `i_rx_data`, in, `NB_BYTE`: received byte.
- `i_rx_valid`, in, 1: one-cycle strobe; the byte is consumed when high.
- `o_tx_data`, out, `NB_BYTE`: byte to transmit.
- `o_tx_valid`, out, 1: transmit request.
- `i_tx_ready`, in, 1: transmitter accepts the byte.
- `i_halt`, in, 1: pipeline has retired HALT.
- `i_dunit_reg`, in, `NB_REG`: register-file read data, combinational from `o_dunit_addr`.
- `o_dunit_clk_en`, out, 1: pipeline clock enable.
- `o_dunit_reset_pc`, out, 1: hold PC at 0.
- `o_dunit_w_mem`, out, 1: instruction-memory write strobe.
- `o_dunit_addr`, out, `NB_REG`: byte address in LOAD state, register index in DUMP state.
- `o_dunit_data_if`, out, `NB_REG`: instruction word to write.
- `o_cycle_count`, out, `NB_CNT`: number of enabled pipeline cycles; saturates at all-ones.
- `o_busy`, out, 1: high in any state other than IDLE.

## Operation
- States: IDLE, LOAD, RUN, STEP, DUMP.
- Reset values:
  - `o_dunit_reset_pc`=1.
  - All other outputs 0.
  - State IDLE, internal halt latch cleared.
- IDLE decodes the bytes accepted on `i_rx_valid`:
  - 0x4C 'L': go to LOAD. Word counter k=0, `o_dunit_reset_pc`=1.
  - 0x43 'C': go to RUN. No effect if the halt latch is set.
  - 0x53 'S': go to STEP. No effect if the halt latch is set.
  - 0x44 'D': go to DUMP.
  - 0x52 'R': `o_dunit_reset_pc`=1, `o_cycle_count`=0, halt latch cleared. Stay in IDLE.
  - Any other byte is ignored.
- LOAD:
  - Bytes are assembled MSB-first into a word.
  - After the `NB_REG/NB_BYTE`-th byte, if word==`END_WORD`: nothing is written and the state returns to IDLE.
  - Otherwise, for one cycle: `o_dunit_w_mem`=1, `o_dunit_addr`=4·k, `o_dunit_data_if`=word. Then k increments.
  - After the write with k=`MEM_DEPTH`-1, the state returns to IDLE.
- RUN:
  - `o_dunit_reset_pc`=0 and `o_dunit_clk_en`=1 every cycle; `o_cycle_count` increments each enabled cycle.
  - Exit to IDLE when `i_halt`=1 (sets the halt latch) or when the count since RUN entry reaches `MAX_CYCLES`.
- STEP:
  - Exactly one cycle with `o_dunit_clk_en`=1 and `o_dunit_reset_pc`=0, count +1, then IDLE.
  - The halt latch is set if `i_halt`=1 during that cycle.
- DUMP, for r=0..`N_REGS`-1:
  - Drive `o_dunit_addr`=r for one settle cycle, then capture `i_dunit_reg`.
  - Send the captured word MSB-first as `NB_REG/NB_BYTE` bytes.
  - After the last byte of register `N_REGS`-1, return to IDLE.
  - `o_dunit_clk_en` stays 0 throughout.
- `i_rx_valid` bytes received outside IDLE/LOAD are dropped.
- `o_dunit_reset_pc` stays 1 from 'L' or 'R' until the next RUN or STEP entry.

## Timing
- The 'L', 'C', 'S', 'D' and 'R' commands take effect on the edge that samples the command byte. The new state's outputs appear the cycle after.
- LOAD write latency: the `o_dunit_w_mem` pulse occurs exactly 1 cycle after the last byte of a word is accepted. Back-to-back bytes in consecutive cycles are supported.
- RUN: `o_dunit_clk_en` is registered.
  - If `i_halt` is sampled high in cycle n, `o_dunit_clk_en` is 0 from cycle n+1.
  - Watchdog: exactly `MAX_CYCLES` enabled cycles, then 0.
- TX handshake:
  - `o_tx_valid` and `o_tx_data` stay stable until a cycle with `o_tx_valid`&&`i_tx_ready`; the byte transfers on that edge.
  - The next byte may be valid in the following cycle.
  - If `i_tx_ready` is held at 1, a dump takes `N_REGS`·(1+`NB_REG/NB_BYTE`) cycles.
- Simultaneous events:
  - `i_halt` and the watchdog limit reached in the same cycle: treated as halt, latch set.
  - A command byte arriving in the same cycle as an exit to IDLE is dropped.
- `i_reset` in any state: next edge restores all reset values and aborts partial words and dumps. `o_tx_valid` drops even mid-handshake.
- Counter saturation: `o_cycle_count` holds at 2^`NB_CNT`-1.

## Test plan
- Load test:
  - Stimulus: 'L', then the bytes of 0x20010005, 0x20020005, 0x10220004, END_WORD.
  - Required: three `o_dunit_w_mem` pulses at addresses 0x0, 0x4, 0x8 with matching data, then IDLE with `o_dunit_reset_pc`=1.
- Run to halt:
  - Stimulus: 'C', with `i_halt` raised at the 10th enabled cycle.
  - Required: `o_dunit_clk_en` low from the next cycle, `o_cycle_count`=10. A subsequent 'C' is ignored.
- Step:
  - Stimulus: 'R', then 'S' three times.
  - Required: three single-cycle `o_dunit_clk_en` pulses and `o_cycle_count`=3.
- Watchdog:
  - Stimulus: `MAX_CYCLES`=16, 'C' with `i_halt`=0.
  - Required: exactly 16 enabled cycles, then IDLE.
- Dump with backpressure:
  - Stimulus: `N_REGS`=4, register values 0,5,5,2; `i_tx_ready` toggling 1/0.
  - Required: 16 bytes 00 00 00 00 00 00 00 05 … 00 00 00 02, each held stable until accepted.
- Reset mid-operation:
  - Stimulus: assert `i_reset` after 2 bytes of a LOAD word.
  - Required: no write occurs, outputs return to reset values, and a new 'L' restarts at address 0.
